alu_seq: RTL

- Multi-byte sequencer for the 8-bit discrete ALU.
- Latches operands of up to MAXB bytes on a start request, then feeds the ALU one byte per step.
- Holds each byte step for a fixed number of cycles to cover ALU propagation delay. Chains carry between bytes and merges per-byte flags into whole-word flags.
- Sits between the CPU control unit and the ALU, so the control unit can issue 16/24/32-bit ops as one request.

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu_seq_flags.sv | 71 +++++++
 rtl/alu_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-byte ALU sequencer: state encoding, flag bit positions
// and default hold time.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDrive  = 2'd1,
    StSample = 2'd2,
    StFinish = 2'd3
  } state_e;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_V = 3;

  localparam int unsigned WAIT_DEFAULT = 3;
  localparam int unsigned CNT_W        = 4;

endpackage

// File: rtl/alu_seq_flags.sv
// Per-operation flag accumulation: running zero, chained carry, MSB sign/overflow capture,
// and the committed whole-word flags register.
module alu_seq_flags
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear_i,
  input  logic       carry_in_i,
  input  logic       step_i,
  input  logic       msb_step_i,
  input  logic       commit_i,
  input  logic [3:0] alu_flags_i,
  output logic       carry_o,
  output logic [3:0] flags_o
);

  logic       zero_q, zero_d;
  logic       carry_q, carry_d;
  logic       sign_q, sign_d;
  logic       ovf_q, ovf_d;
  logic [3:0] flags_q, flags_d;

  always_comb begin
    zero_d  = zero_q;
    carry_d = carry_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    flags_d = flags_q;
    if (clear_i) begin
      // The chained carry starts as the caller's carry so the first step needs no special case.
      zero_d  = 1'b1;
      carry_d = carry_in_i;
      sign_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (step_i) begin
      zero_d  = zero_q & alu_flags_i[FLAG_Z];
      carry_d = alu_flags_i[FLAG_C];
      if (msb_step_i) begin
        sign_d = alu_flags_i[FLAG_S];
        ovf_d  = alu_flags_i[FLAG_V];
      end
    end
    if (commit_i) begin
      flags_d[FLAG_Z] = zero_d;
      flags_d[FLAG_C] = carry_d;
      flags_d[FLAG_S] = sign_d;
      flags_d[FLAG_V] = ovf_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      flags_q <= '0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      flags_q <= flags_d;
    end
  end

  assign carry_o = carry_q;
  assign flags_o = flags_q;

endmodule

// File: rtl/alu_seq.sv
// Multi-byte sequencer for the 8-bit ALU: latches wide operands, steps one byte at a time
// with a fixed hold time, chains carry and assembles result and merged flags.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned MAXB = 4,
  parameter int unsigned WAIT = WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic              invert,
  input  logic              carry_in,
  input  logic              msb_first,
  input  logic [1:0]        nbytes,
  input  logic [8*MAXB-1:0] a,
  input  logic [8*MAXB-1:0] b,
  input  logic              abort,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [3:0]        alu_op,
  output logic              alu_invert,
  output logic              alu_carry,
  output logic              alu_n_oe,
  input  logic [7:0]        alu_result,
  input  logic [3:0]        alu_flags,
  output logic              busy,
  output logic              done,
  output logic [8*MAXB-1:0] result,
  output logic [3:0]        flags
);

  localparam int unsigned W = 8 * MAXB;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic              inv_q, inv_d;
  logic              msb_q, msb_d;
  logic [1:0]        nb_q, nb_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [W-1:0]      shadow_q, shadow_d;
  logic [W-1:0]      result_q, result_d;

  logic              accept, last_step, wait_done, in_step, commit, carry_chain;
  logic [1:0]        nb_clamp;
  logic [7:0]        byte_a, byte_b;

  assign accept    = (state_q == StIdle) && start;
  assign nb_clamp  = (32'(nbytes) >= MAXB) ? 2'(MAXB - 1) : nbytes;
  assign last_step = msb_q ? (idx_q == 2'd0) : (idx_q == nb_q);
  assign wait_done = (cnt_q == CNT_W'(WAIT - 1));
  assign in_step   = (state_q == StDrive) || (state_q == StSample);
  assign commit    = (state_q == StSample) && last_step && !abort;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StDrive;
      StDrive: begin
        if (abort)          state_d = StIdle;
        else if (wait_done) state_d = StSample;
      end
      StSample: begin
        if (abort)          state_d = StIdle;
        else if (last_step) state_d = StFinish;
        else                state_d = StDrive;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    byte_a = '0;
    byte_b = '0;
    for (int unsigned i = 0; i < MAXB; i++) begin
      if (idx_q == 2'(i)) begin
        byte_a = a_q[8*i +: 8];
        byte_b = b_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    op_d     = op_q;
    inv_d    = inv_q;
    msb_d    = msb_q;
    nb_d     = nb_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    shadow_d = shadow_q;
    result_d = result_q;
    if (accept) begin
      op_d     = op;
      inv_d    = invert;
      msb_d    = msb_first;
      nb_d     = nb_clamp;
      idx_d    = msb_first ? nb_clamp : 2'd0;
      cnt_d    = '0;
      a_d      = a;
      b_d      = b;
      shadow_d = '0;
    end else if (state_q == StDrive) begin
      cnt_d = cnt_q + 1'b1;
    end else if (state_q == StSample) begin
      // Partial bytes live in the shadow; the visible result only changes on commit.
      for (int unsigned i = 0; i < MAXB; i++) begin
        if (idx_q == 2'(i)) shadow_d[8*i +: 8] = alu_result;
      end
      cnt_d = '0;
      if (!last_step) idx_d = msb_q ? idx_q - 2'd1 : idx_q + 2'd1;
    end
    if (commit) result_d = shadow_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      op_q     <= '0;
      inv_q    <= 1'b0;
      msb_q    <= 1'b0;
      nb_q     <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      inv_q    <= inv_d;
      msb_q    <= msb_d;
      nb_q     <= nb_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
    end
  end

  alu_seq_flags u_flags (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear_i    (accept),
    .carry_in_i (carry_in),
    .step_i     (state_q == StSample),
    .msb_step_i (idx_q == nb_q),
    .commit_i   (commit),
    .alu_flags_i(alu_flags),
    .carry_o    (carry_chain),
    .flags_o    (flags)
  );

  always_comb begin
    busy       = in_step;
    done       = (state_q == StFinish);
    alu_n_oe   = !in_step;
    alu_a      = in_step ? byte_a : 8'h00;
    alu_b      = in_step ? byte_b : 8'h00;
    alu_op     = in_step ? op_q : 4'h0;
    alu_invert = in_step && inv_q;
    alu_carry  = in_step && carry_chain;
  end

  assign result = result_q;

endmodule
